// File: rtl/arr_out_drain.sv
// arr_out_drain
//   Collects result rows leaving the bottom edge of the systolic array.
//   Each column is delayed so that all columns of a row line up. The aligned
//   row is requantized (shift, round half up, saturate) and pushed into a row
//   FIFO. The FIFO is drained one word at a time, column 0 first.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; candidate rows are discarded
//   RUN    | rows are buffered and streamed; busy=1
//   DONE   | one-cycle done pulse; buffered extra rows are flushed on entry
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse; latches total_rows and shamt
//   total_rows, shamt   row count before done, requantization right shift
//   col_valid, col_dat  skewed per-column results from the array
//   out_valid/ready     word stream handshake; out_dat, out_last with it
//   almost_full         FIFO occupancy >= ROWBUF-1
//   overflow, skew_err  sticky error flags, cleared by start
//   busy, done          RUN indicator, one-cycle completion pulse
module arr_out_drain #(
    parameter int COLS    = 16,
    parameter int ACCLEN  = 16,
    parameter int WORDLEN = 8,
    parameter int ROWBUF  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              total_rows,
    input  logic [3:0]               shamt,
    input  logic [COLS-1:0]          col_valid,
    input  logic [COLS*ACCLEN-1:0]   col_dat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDLEN-1:0]       out_dat,
    output logic                     out_last,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     skew_err,
    output logic                     busy,
    output logic                     done
);

    localparam int WIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW  = (ROWBUF > 1) ? $clog2(ROWBUF) : 1;
    localparam int CW  = $clog2(ROWBUF + 1);

    localparam logic signed [ACCLEN:0] SAT_HI = (ACCLEN+1)'(2**(WORDLEN-1) - 1);
    localparam logic signed [ACCLEN:0] SAT_LO = (ACCLEN+1)'(-(2**(WORDLEN-1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         tot_q;
    logic [15:0]         row_cnt_q;
    logic [3:0]          sh_q;

    logic [COLS-1:0]     al_v;
    logic [ACCLEN-1:0]   al_d [COLS];

    logic                cmt_v_q;
    logic [WORDLEN-1:0]  cmt_row_q [COLS];

    logic [WORDLEN-1:0]  mem [ROWBUF][COLS];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [WIW-1:0]      wi;

    logic                run;
    logic                full;
    logic                push_req;
    logic                push;
    logic                hs;
    logic                pop;
    logic                flush;

    // Deskew: column c waits COLS-1-c cycles so it lines up with column COLS-1.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_raw
            assign al_v[c] = col_valid[c];
            assign al_d[c] = col_dat[c*ACCLEN +: ACCLEN];
        end else begin : g_dly
            logic [D-1:0]      v_sr;
            logic [ACCLEN-1:0] d_sr [D];
            always_ff @(posedge clk) begin
                if (rst) v_sr <= '0;
                else     v_sr <= (v_sr << 1) | D'(col_valid[c]);
            end
            always_ff @(posedge clk) begin
                d_sr[0] <= col_dat[c*ACCLEN +: ACCLEN];
                for (int k = 1; k < D; k++) d_sr[k] <= d_sr[k-1];
            end
            assign al_v[c] = v_sr[D-1];
            assign al_d[c] = d_sr[D-1];
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [WORDLEN-1:0] requant(input logic [ACCLEN-1:0] acc,
                                                  input logic [3:0] sh);
        logic signed [ACCLEN:0] rnd;
        logic signed [ACCLEN:0] sum;
        logic signed [ACCLEN:0] shf;
        rnd = '0;
        if (sh != 4'd0) rnd = (ACCLEN+1)'(1) << (sh - 4'd1);
        sum = $signed({acc[ACCLEN-1], acc}) + rnd;
        shf = sum >>> sh;
        if (shf > SAT_HI)      shf = SAT_HI;
        else if (shf < SAT_LO) shf = SAT_LO;
        return shf[WORDLEN-1:0];
    endfunction

    assign run      = (state_q == S_RUN);
    assign push_req = cmt_v_q && run;
    assign full     = (count == CW'(ROWBUF));
    assign push     = push_req && !full;
    assign hs       = out_valid && out_ready;
    assign pop      = hs && (wi == WIW'(COLS-1));
    assign flush    = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) cmt_v_q <= 1'b0;
        else     cmt_v_q <= run && (&al_v);
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) cmt_row_q[c] <= requant(al_d[c], sh_q);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int c = 0; c < COLS; c++) mem[wr_ptr][c] <= cmt_row_q[c];
        end
    end

    // The full check sees pre-edge occupancy, so a same-cycle pop never makes room.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wi     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (hs) wi <= pop ? '0 : wi + WIW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q     <= '0;
            sh_q      <= '0;
            row_cnt_q <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            tot_q     <= total_rows;
            sh_q      <= shamt;
            row_cnt_q <= '0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            if (push_req && full)               overflow  <= 1'b1;
            if (run && (|al_v) && !(&al_v))     skew_err  <= 1'b1;
            if (pop)                            row_cnt_q <= row_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (total_rows == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (pop && row_cnt_q == tot_q - 16'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Word outputs are gated so that stale FIFO contents never show after reset.
    always_comb begin
        out_valid   = 1'b0;
        out_dat     = '0;
        out_last    = 1'b0;
        almost_full = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        out_valid   = (count != '0);
        if (out_valid) begin
            out_dat  = mem[rd_ptr][wi];
            out_last = (wi == WIW'(COLS-1));
        end
        almost_full = (count >= CW'(ROWBUF-1));
        busy        = run;
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_arr_out_drain.sv
// Bench for arr_out_drain (COLS=4, ROWBUF=4). A row-level model predicts all
// outputs every cycle; directed sections add literal expectations.
module tb_arr_out_drain;

    localparam int COLS    = 4;
    localparam int ACCLEN  = 16;
    localparam int WORDLEN = 8;
    localparam int ROWBUF  = 4;

    typedef int row_t [COLS];

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [15:0]            total_rows;
    logic [3:0]             shamt;
    logic [COLS-1:0]        col_valid;
    logic [COLS*ACCLEN-1:0] col_dat;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORDLEN-1:0]     out_dat;
    logic                   out_last;
    logic                   almost_full;
    logic                   overflow;
    logic                   skew_err;
    logic                   busy;
    logic                   done;

    arr_out_drain #(.COLS(COLS), .ACCLEN(ACCLEN), .WORDLEN(WORDLEN), .ROWBUF(ROWBUF)) dut (
        .clk(clk), .rst(rst), .start(start), .total_rows(total_rows), .shamt(shamt),
        .col_valid(col_valid), .col_dat(col_dat), .out_valid(out_valid),
        .out_ready(out_ready), .out_dat(out_dat), .out_last(out_last),
        .almost_full(almost_full), .overflow(overflow), .skew_err(skew_err),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit chk_en = 0;

    // input schedule ring: slot = cycle % 16
    bit   in_v [16][COLS];
    int   in_d [16][COLS];
    // model: rows aligning / landing in the FIFO, keyed by cycle % 16
    int   al_kind [16];
    row_t al_raw  [16];
    bit   land_ok [16];
    row_t land_w  [16];

    row_t mq[$];
    int   m_wi, m_rows, m_total, m_sh;
    bit   m_run, m_done, m_ovf, m_skew;

    int   cap[$];
    int   first_v, done_cyc, last_hs;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    endtask

    function automatic int rq(input int acc, input int sh);
        int v;
        v = acc;
        if (sh > 0) v = v + (1 << (sh - 1));
        v = v >>> sh;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic inject(input logic [COLS-1:0] mask, input row_t d);
        int s;
        for (int c = 0; c < COLS; c++) begin
            in_v[(cyc + c) % 16][c] = mask[c];
            in_d[(cyc + c) % 16][c] = d[c];
        end
        s = (cyc + COLS - 1) % 16;
        al_kind[s] = (mask == '1) ? 1 : ((mask == '0) ? 0 : 2);
        al_raw[s]  = d;
    endtask

    task automatic model_edge();
        int   s;
        int   sz;
        bit   hs, lst, do_push;
        row_t nr;
        s  = cyc % 16;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_wi = 0; m_rows = 0; m_total = 0; m_sh = 0;
            m_run = 0; m_done = 0; m_ovf = 0; m_skew = 0;
            for (int i = 0; i < 16; i++) begin
                al_kind[i] = 0;
                land_ok[i] = 0;
            end
            return;
        end
        hs  = (sz > 0) && out_ready;
        lst = hs && (m_wi == COLS - 1);
        do_push = 0;
        if (land_ok[s]) begin
            land_ok[s] = 0;
            if (m_run) begin
                if (sz == ROWBUF) m_ovf = 1;
                else begin
                    do_push = 1;
                    nr = land_w[s];
                end
            end
        end
        if (m_run && al_kind[s] == 1) begin
            land_ok[(s + 1) % 16] = 1;
            for (int c = 0; c < COLS; c++) land_w[(s + 1) % 16][c] = rq(al_raw[s][c], m_sh);
        end
        if (m_run && al_kind[s] == 2) m_skew = 1;
        al_kind[s] = 0;
        if (hs) begin
            if (lst) begin
                void'(mq.pop_front());
                m_wi = 0;
                m_rows++;
            end else m_wi++;
        end
        if (do_push) mq.push_back(nr);
        if (m_done) m_done = 0;
        else if (m_run) begin
            if (lst && m_rows == m_total) begin
                m_run = 0; m_done = 1; mq.delete(); m_wi = 0;
            end
        end else if (start) begin
            m_total = int'(total_rows); m_sh = int'(shamt);
            m_rows = 0; m_ovf = 0; m_skew = 0;
            if (total_rows == 16'd0) m_done = 1;
            else m_run = 1;
        end
    endtask

    task automatic step();
        int s;
        if (chk_en) begin
            check("out_valid", int'(out_valid), int'(mq.size() > 0));
            if (mq.size() > 0) check("out_dat", int'($signed(out_dat)), mq[0][m_wi]);
            check("out_last", int'(out_last), int'(mq.size() > 0 && m_wi == COLS - 1));
            check("almost_full", int'(almost_full), int'(mq.size() >= ROWBUF - 1));
            check("overflow", int'(overflow), int'(m_ovf));
            check("skew_err", int'(skew_err), int'(m_skew));
            check("busy", int'(busy), int'(m_run));
            check("done", int'(done), int'(m_done));
        end
        if (out_valid && out_ready) cap.push_back(int'($signed(out_dat)));
        if (out_valid && first_v < 0) first_v = cyc;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (out_valid && out_ready && out_last) last_hs = cyc;
        s = cyc % 16;
        col_valid = '0;
        col_dat   = '0;
        if (rst) begin
            for (int i = 0; i < 16; i++)
                for (int c = 0; c < COLS; c++) in_v[i][c] = 0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                col_valid[c] = in_v[s][c];
                col_dat[c*ACCLEN +: ACCLEN] = in_d[s][c][ACCLEN-1:0];
                in_v[s][c] = 0;
            end
        end
        model_edge();
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input int tot, input int sh);
        total_rows = 16'(tot);
        shamt      = 4'(sh);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic clear_obs();
        cap.delete();
        first_v = -1; done_cyc = -1; last_hs = -1;
    endtask

    task automatic check_cap(input string nm, input row_t exp);
        check({nm, "_count"}, cap.size(), COLS);
        if (cap.size() == COLS)
            for (int i = 0; i < COLS; i++) check({nm, "_word"}, cap[i], exp[i]);
    endtask

    row_t r;
    int   t0;
    int   budget;
    bit   reached;

    initial begin
        rst = 1'b1; start = 1'b0; total_rows = '0; shamt = '0; out_ready = 1'b0;
        col_valid = '0; col_dat = '0;
        for (int i = 0; i < 16; i++) begin
            al_kind[i] = 0; land_ok[i] = 0;
            for (int c = 0; c < COLS; c++) begin in_v[i][c] = 0; in_d[i][c] = 0; end
        end
        clear_obs();
        step(); step();
        chk_en = 1;
        step();
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // basic row, shamt 0, saturation of -200
        clear_obs();
        out_ready = 1'b1;
        start_run(1, 0);
        t0 = cyc;
        r = '{5, -3, 100, -200};
        inject(4'hF, r);
        repeat (12) step();
        check_cap("t1", '{5, -3, 100, -128});
        check("t1_latency", first_v, t0 + 5);
        check("t1_done_cycle", done_cyc, last_hs + 1);

        // rounding and saturation with shamt 2
        clear_obs();
        start_run(1, 2);
        r = '{6, 7, -6, 1000};
        inject(4'hF, r);
        repeat (12) step();
        check_cap("t2", '{2, 2, -1, 127});

        // overflow: 5 back-to-back rows into a stalled 4-row FIFO
        clear_obs();
        out_ready = 1'b0;
        start_run(4, 0);
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < COLS; c++) r[c] = 10 * i + c;
            inject(4'hF, r);
            step();
        end
        repeat (6) step();
        check("t3_overflow", int'(overflow), 1);
        check("t3_almost_full", int'(almost_full), 1);
        out_ready = 1'b1;
        repeat (25) step();
        check("t3_words", cap.size(), 16);
        if (cap.size() == 16)
            for (int i = 0; i < 16; i++) check("t3_word", cap[i], 10 * (i / 4) + (i % 4));
        check("t3_done_seen", int'(done_cyc >= 0), 1);

        // partial valid set drops the row and sets skew_err
        clear_obs();
        start_run(2, 0);
        r = '{1, 2, 3, 4};
        inject(4'b1011, r);
        step(); step();
        r = '{11, 12, 13, 14};
        inject(4'hF, r);
        step(); step();
        r = '{21, 22, 23, 24};
        inject(4'hF, r);
        repeat (14) step();
        check("t4_skew_err", int'(skew_err), 1);
        check("t4_words", cap.size(), 8);
        if (cap.size() == 8) begin
            check("t4_first", cap[0], 11);
            check("t4_second_row", cap[4], 21);
        end

        // out_ready toggling every cycle
        clear_obs();
        start_run(2, 0);
        r = '{31, 32, 33, 34};
        inject(4'hF, r);
        step();
        r = '{41, 42, 43, 44};
        inject(4'hF, r);
        for (int i = 0; i < 26; i++) begin
            out_ready = 1'(cyc % 2);
            step();
        end
        check("t5_words", cap.size(), 8);
        if (cap.size() == 8)
            for (int i = 0; i < 8; i++) check("t5_word", cap[i], 31 + 10 * (i / 4) + (i % 4));

        // reset in the middle of the second row's output
        clear_obs();
        out_ready = 1'b1;
        start_run(3, 0);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < COLS; c++) r[c] = 50 + 10 * i + c;
            inject(4'hF, r);
            step(); step();
        end
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (m_rows == 1 && m_wi == 2) reached = 1;
            else step();
        end
        check("t6_reset_point_reached", int'(reached), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_almost_full", int'(almost_full), 0);
        check("t6_out_last", int'(out_last), 0);
        clear_obs();
        start_run(1, 3);
        r = '{8, -8, 100, -1000};
        inject(4'hF, r);
        repeat (12) step();
        check_cap("t6_after_rst", '{1, -1, 13, -125});

        // randomized runs against the model
        for (int run = 0; run < 14; run++) begin
            clear_obs();
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 1) == 0) begin
                    for (int c = 0; c < COLS; c++) r[c] = int'($signed(16'($urandom)));
                    inject(4'hF, r);
                end
                step();
            end
            start_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
            budget = 0;
            while ((m_run || m_done) && budget < 400) begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int c = 0; c < COLS; c++) r[c] = int'($signed(16'($urandom)));
                    if ($urandom_range(0, 5) == 0) inject(4'(1 + $urandom_range(0, 13)), r);
                    else inject(4'hF, r);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 40) == 0) begin
                    start = 1'b1;
                    total_rows = 16'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 299) == 0) rst = 1'b1;
                step();
                start = 1'b0;
                rst = 1'b0;
                budget++;
            end
            if (budget >= 400) begin
                check("random_run_bounded", 0, 1);
                rst = 1'b1; step(); rst = 1'b0;
            end
        end
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
